// File: rtl/pipeline_control_chain.sv
// Control-path half of a 5-stage pipeline: carries the ID-stage control bundle through
// ID/EX, EX/MEM and MEM/WB, resolves load-use stalls and taken-branch flushes, and generates EX forwarding selects.
module pipeline_control_chain #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             Branch,
    input  logic             MemRead,
    input  logic             MemtoReg,
    input  logic             MemWrite,
    input  logic             ALUSrc,
    input  logic             RegWrite,
    input  logic [1:0]       ALUOp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             alu_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src,
    output logic             ex_ALUSrc,
    output logic [1:0]       ex_ALUOp,
    output logic             ex_Branch,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } idex_t;

    typedef struct packed {
        logic       valid;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic [4:0] rd;
    } exmem_t;

    typedef struct packed {
        logic       valid;
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } memwb_t;

    idex_t  ex_reg,  ex_next;
    exmem_t mem_reg, mem_next;
    memwb_t wb_reg,  wb_next;

    logic branch_taken;
    logic load_use;
    logic stall;
    logic insert_bubble;
    logic memtoreg_clean;
    logic live;

    assign live = ~reset;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign branch_taken = ex_reg.valid & ex_reg.branch & alu_zero;

    assign load_use = id_valid & ex_reg.valid & ex_reg.memread & (ex_reg.rd != 5'd0)
                    & ((ex_reg.rd == id_rs1) | (ex_reg.rd == id_rs2));

    // A taken branch discards the ID instruction anyway, so it outranks the stall.
    assign stall         = load_use & ~branch_taken;
    assign insert_bubble = branch_taken | stall;

    // Store and branch decodes leave MemtoReg undriven; only a definite 1 with a write survives.
    assign memtoreg_clean = RegWrite & (MemtoReg === 1'b1);

    // ------------------------------------------------------------------
    // Stage next-state
    // ------------------------------------------------------------------
    always_comb begin
        ex_next = '0;
        if (!insert_bubble) begin
            ex_next.valid    = id_valid;
            ex_next.branch   = Branch;
            ex_next.memread  = MemRead;
            ex_next.memtoreg = memtoreg_clean;
            ex_next.memwrite = MemWrite;
            ex_next.alusrc   = ALUSrc;
            ex_next.regwrite = RegWrite;
            ex_next.aluop    = ALUOp;
            ex_next.rd       = id_rd;
            ex_next.rs1      = id_rs1;
            ex_next.rs2      = id_rs2;
        end
    end

    always_comb begin
        mem_next = '0;
        if (ex_reg.valid) begin
            mem_next.valid    = 1'b1;
            mem_next.memread  = ex_reg.memread;
            mem_next.memtoreg = ex_reg.memtoreg;
            mem_next.memwrite = ex_reg.memwrite;
            mem_next.regwrite = ex_reg.regwrite;
            mem_next.rd       = ex_reg.rd;
        end
    end

    always_comb begin
        wb_next = '0;
        if (mem_reg.valid) begin
            wb_next.valid    = 1'b1;
            wb_next.memtoreg = mem_reg.memtoreg;
            wb_next.regwrite = mem_reg.regwrite;
            wb_next.rd       = mem_reg.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= mem_next;
            wb_reg  <= wb_next;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects, one per EX source operand
    // ------------------------------------------------------------------
    logic [4:0] ex_rs   [2];
    logic [1:0] fwd_sel [2];

    assign ex_rs[0] = ex_reg.rs1;
    assign ex_rs[1] = ex_reg.rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] sel_next;
            always_comb begin
                sel_next = 2'b00;
                if (mem_reg.valid && mem_reg.regwrite && (mem_reg.rd != 5'd0)
                        && (mem_reg.rd == ex_rs[gi])) begin
                    sel_next = 2'b10;
                end else if (wb_reg.valid && wb_reg.regwrite && (wb_reg.rd != 5'd0)
                        && (wb_reg.rd == ex_rs[gi])) begin
                    sel_next = 2'b01;
                end
            end
            assign fwd_sel[gi] = sel_next;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturating event counters: index 0 counts stalls, index 1 counts flushes
    // ------------------------------------------------------------------
    logic [1:0]       cnt_event;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_event = {branch_taken, stall};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign stall_count = cnt_val[0];
    assign flush_count = cnt_val[1];

    // ------------------------------------------------------------------
    // Outputs: gated by stage valid and forced quiet while reset is held
    // ------------------------------------------------------------------
    logic ex_on, mem_on, wb_on;

    assign ex_on  = live & ex_reg.valid;
    assign mem_on = live & mem_reg.valid;
    assign wb_on  = live & wb_reg.valid;

    assign pc_write   = live & ~stall;
    assign ifid_write = live & ~stall;
    assign ifid_flush = live & branch_taken;
    assign pc_src     = live & branch_taken;

    assign ex_ALUSrc    = ex_on & ex_reg.alusrc;
    assign ex_ALUOp     = {2{ex_on}} & ex_reg.aluop;
    assign ex_Branch    = ex_on & ex_reg.branch;
    assign ex_rd        = {5{ex_on}} & ex_reg.rd;

    assign mem_MemRead  = mem_on & mem_reg.memread;
    assign mem_MemWrite = mem_on & mem_reg.memwrite;
    assign mem_rd       = {5{mem_on}} & mem_reg.rd;

    assign wb_RegWrite  = wb_on & wb_reg.regwrite;
    assign wb_MemtoReg  = wb_on & wb_reg.memtoreg;
    assign wb_rd        = {5{wb_on}} & wb_reg.rd;

    assign forward_a = {2{live}} & fwd_sel[0];
    assign forward_b = {2{live}} & fwd_sel[1];

endmodule

// File: tb/tb_pipeline_control_chain.sv
// Directed bench for pipeline_control_chain: hand-computed expectations for advance,
// load-use stall, branch flush, forwarding, MemtoReg sanitising, counter saturation and reset.
module tb_pipeline_control_chain;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]       ALUOp;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             alu_zero;
    logic             pc_write, ifid_write, ifid_flush, pc_src;
    logic             ex_ALUSrc;
    logic [1:0]       ex_ALUOp;
    logic             ex_Branch;
    logic             mem_MemRead, mem_MemWrite;
    logic             wb_RegWrite, wb_MemtoReg;
    logic [4:0]       ex_rd, mem_rd, wb_rd;
    logic [1:0]       forward_a, forward_b;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_fails  = 0;

    pipeline_control_chain #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .Branch       (Branch),
        .MemRead      (MemRead),
        .MemtoReg     (MemtoReg),
        .MemWrite     (MemWrite),
        .ALUSrc       (ALUSrc),
        .RegWrite     (RegWrite),
        .ALUOp        (ALUOp),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .alu_zero     (alu_zero),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .pc_src       (pc_src),
        .ex_ALUSrc    (ex_ALUSrc),
        .ex_ALUOp     (ex_ALUOp),
        .ex_Branch    (ex_Branch),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .wb_RegWrite  (wb_RegWrite),
        .wb_MemtoReg  (wb_MemtoReg),
        .ex_rd        (ex_rd),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic br, input logic mr, input logic m2r,
                         input logic mw, input logic as, input logic rw, input logic [1:0] op,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v;
        Branch   = br;
        MemRead  = mr;
        MemtoReg = m2r;
        MemWrite = mw;
        ALUSrc   = as;
        RegWrite = rw;
        ALUOp    = op;
        id_rs1   = r1;
        id_rs2   = r2;
        id_rd    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        alu_zero = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset    = 1'b1;
        alu_zero = 1'b0;
        idle();
        tick();
        tick();
        #1;
        check_val("rst_pc_write",    16'(pc_write),    16'd0);
        check_val("rst_ifid_write",  16'(ifid_write),  16'd0);
        check_val("rst_ifid_flush",  16'(ifid_flush),  16'd0);
        check_val("rst_forward_a",   16'(forward_a),   16'd0);
        check_val("rst_ex_rd",       16'(ex_rd),       16'd0);
        check_val("rst_stall_count", 16'(stall_count), 16'd0);
        reset = 1'b0;
        #1;
        check_val("post_rst_pc_write",   16'(pc_write),   16'd1);
        check_val("post_rst_ifid_write", 16'(ifid_write), 16'd1);

        // ---------------- straight-line R-type ----------------
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd1, 5'd2, 5'd5);
        #1;
        check_val("rtype_no_stall", 16'(pc_write), 16'd1);
        tick();
        idle();
        #1;
        check_val("rtype_ex_aluop", 16'(ex_ALUOp), 16'd2);
        check_val("rtype_ex_rd",    16'(ex_rd),    16'd5);
        tick();
        #1;
        check_val("rtype_mem_rd",   16'(mem_rd),   16'd5);
        tick();
        #1;
        check_val("rtype_wb_regwrite", 16'(wb_RegWrite), 16'd1);
        check_val("rtype_wb_rd",       16'(wb_rd),       16'd5);
        check_val("rtype_stall_count", 16'(stall_count), 16'd0);

        // ---------------- load-use ----------------
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd7);
        #1;
        check_val("lu_ld_no_stall", 16'(pc_write), 16'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd4, 5'd7, 5'd8);
        #1;
        check_val("lu_stall_pc_write",   16'(pc_write),   16'd0);
        check_val("lu_stall_ifid_write", 16'(ifid_write), 16'd0);
        tick();
        #1;
        check_val("lu_bubble_aluop",   16'(ex_ALUOp),    16'd0);
        check_val("lu_bubble_alusrc",  16'(ex_ALUSrc),   16'd0);
        check_val("lu_bubble_rd",      16'(ex_rd),       16'd0);
        check_val("lu_one_cycle_only", 16'(pc_write),    16'd1);
        check_val("lu_stall_count",    16'(stall_count), 16'd1);
        tick();
        idle();
        #1;
        check_val("lu_forward_b",      16'(forward_b),   16'd1);
        check_val("lu_forward_a",      16'(forward_a),   16'd0);
        check_val("lu_add_ex_rd",      16'(ex_rd),       16'd8);
        check_val("lu_stall_count_2",  16'(stall_count), 16'd1);

        // ---------------- taken branch vs simultaneous load-use ----------------
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 5'd2, 5'd7);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd7, 5'd3, 5'd9);
        alu_zero = 1'b0;
        #1;
        check_val("br_ex_branch",      16'(ex_Branch),  16'd1);
        check_val("br_untaken_stall",  16'(pc_write),   16'd0);
        check_val("br_untaken_flush",  16'(ifid_flush), 16'd0);
        alu_zero = 1'b1;
        #1;
        check_val("br_taken_flush",    16'(ifid_flush), 16'd1);
        check_val("br_taken_pc_src",   16'(pc_src),     16'd1);
        check_val("br_taken_pc_write", 16'(pc_write),   16'd1);
        check_val("br_taken_ifid_wr",  16'(ifid_write), 16'd1);
        tick();
        alu_zero = 1'b0;
        idle();
        #1;
        check_val("br_bubble_rd",      16'(ex_rd),       16'd0);
        check_val("br_bubble_aluop",   16'(ex_ALUOp),    16'd0);
        check_val("br_flush_count",    16'(flush_count), 16'd1);
        check_val("br_stall_count",    16'(stall_count), 16'd0);

        // ---------------- double forward, EX/MEM priority ----------------
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd0, 5'd3);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd3, 5'd6, 5'd4);
        tick();
        idle();
        #1;
        check_val("fwd_a_exmem_prio", 16'(forward_a), 16'd2);
        check_val("fwd_b_none",       16'(forward_b), 16'd0);

        // same chain targeting x0: no forward even though rd and rs1 agree
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 5'd6, 5'd4);
        tick();
        idle();
        #1;
        check_val("fwd_a_x0", 16'(forward_a), 16'd0);

        // ---------------- MemtoReg sanitising ----------------
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'bx, 1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 5'd5, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 5'd6, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd2, 5'd0, 5'd9);
        #1;
        check_val("sd_mem_memwrite", 16'(mem_MemWrite), 16'd1);
        check_val("sd_no_stall",     16'(pc_write),     16'd1);
        tick();
        idle();
        #1;
        check_val("sd_x_wb_memtoreg",  16'(wb_MemtoReg), 16'd0);
        check_val("sd_x_wb_regwrite",  16'(wb_RegWrite), 16'd0);
        tick();
        #1;
        check_val("sd_rw0_wb_memtoreg", 16'(wb_MemtoReg), 16'd0);
        tick();
        #1;
        check_val("ld_wb_memtoreg", 16'(wb_MemtoReg), 16'd1);
        check_val("ld_wb_rd",       16'(wb_rd),       16'd9);

        // ---------------- counter saturation and reset mid-stall ----------------
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd7, 5'd0, 5'd7);
        repeat (4) tick();
        #1;
        check_val("sat_stall_count_2", 16'(stall_count), 16'd2);
        repeat (2) tick();
        #1;
        check_val("sat_stall_count_3", 16'(stall_count), 16'd3);
        repeat (4) tick();
        #1;
        check_val("sat_stall_hold",    16'(stall_count), 16'd3);
        tick();
        check_val("sat_mid_stall",     16'(pc_write),    16'd0);
        reset = 1'b1;
        #1;
        check_val("rst_in_stall_pc_write", 16'(pc_write), 16'd0);
        check_val("rst_in_stall_ex_rd",    16'(ex_rd),    16'd0);
        check_val("rst_in_stall_wb_rd",    16'(wb_rd),    16'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check_val("post_rst_stall_count", 16'(stall_count), 16'd0);
        check_val("post_rst_flush_count", 16'(flush_count), 16'd0);
        check_val("post_rst_ex_rd",       16'(ex_rd),       16'd0);
        check_val("post_rst_ex_aluop",    16'(ex_ALUOp),    16'd0);
        check_val("post_rst_mem_memread", 16'(mem_MemRead), 16'd0);
        check_val("post_rst_wb_regwrite", 16'(wb_RegWrite), 16'd0);
        check_val("post_rst_wb_rd",       16'(wb_rd),       16'd0);
        check_val("post_rst_forward_b",   16'(forward_b),   16'd0);
        check_val("post_rst_pc_write",    16'(pc_write),    16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
